// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmitter.
// UART_PARITY_EN adds an even-parity bit between data and stop.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int DATA_BITS        = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: one-cycle o_tick on the last cycle of each bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (CLKS_PER_BIT <= 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = w_last && !i_clear;

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_top.sv
// UART transmitter: start, 8 data bits LSB first, stop.
// Define UART_PARITY_EN to insert an even-parity bit before stop.
module uart_top
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] sw,
    output logic       o_txd
);

    uart_state_e r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_idx;
    logic        r_txd;
`ifdef UART_PARITY_EN
    logic        r_par;
`endif
    logic        w_tick;
    logic        w_clear;

    // Counter is held at zero in IDLE so each frame starts on a clean bit
    assign w_clear = (r_state == IDLE);
    assign o_txd   = r_txd;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clear(w_clear),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_txd   <= 1'b1;
`ifdef UART_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (i_start) begin
                        r_shift <= sw;
`ifdef UART_PARITY_EN
                        r_par   <= even_parity(sw);
`endif
                        r_state <= START;
                        r_txd   <= 1'b0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_idx   <= '0;
                        r_txd   <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_idx == 3'd7) begin
                            r_idx   <= '0;
`ifdef UART_PARITY_EN
                            r_state <= PARITY;
                            r_txd   <= r_par;
`else
                            r_state <= STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_txd   <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_state <= STOP;
                        r_txd   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_txd   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top with CLKS_PER_BIT=4.
// Expected line values come from a frame model of the byte sent.
module tb_uart_top;
    import uart_pkg::*;

    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       i_reset;
    logic       i_start;
    logic [7:0] sw;
    logic       o_txd;

    int errors = 0;
    int checks = 0;

    uart_top #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_clk  (clk),
        .i_reset(i_reset),
        .i_start(i_start),
        .sw     (sw),
        .o_txd  (o_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        checks++;
        assert (dut.r_state === IDLE)
        else begin
            errors++;
            $error("FAIL %s state observed=%0d expected=IDLE", tag, dut.r_state);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Frame starts on the next edge; ends after its single idle cycle.
    task automatic run_frame(input logic [7:0] d, input int chg_at,
                             input logic [7:0] nsw, input int drop_at,
                             input string tag);
        for (int s = 0; s < NB * CPB; s++) begin
            if (s == chg_at) sw = nsw;
            if (s == drop_at) i_start = 1'b0;
            step();
            chk($sformatf("%s_b%0d_c%0d", tag, s / CPB, s % CPB),
                o_txd, exp_bit(d, s / CPB));
        end
        step();
        chk({tag, "_idle"}, o_txd, 1'b1);
        chk_idle({tag, "_idle_st"});
    endtask

    initial begin
        i_reset = 1'b0;
        i_start = 1'b1;
        sw      = 8'hA5;

        step();
        chk("rst_e1", o_txd, 1'b1);
        chk_idle("rst_e1_st");
        step();
        chk("rst_e2", o_txd, 1'b1);
        chk_idle("rst_e2_st");

        i_reset = 1'b1;
        run_frame(8'hA5, -1, 8'h00, -1, "a5");

        sw = 8'h00;
        run_frame(8'h00, 20, 8'h01, -1, "f00");
        run_frame(8'h01, -1, 8'h00, -1, "f01");

        i_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("hold_idle", o_txd, 1'b1);
        end

        sw      = 8'hFF;
        i_start = 1'b1;
        for (int s = 0; s < 18; s++) begin
            step();
            chk($sformatf("ff_part_s%0d", s), o_txd, exp_bit(8'hFF, s / CPB));
        end
        i_reset = 1'b0;
        step();
        chk("midrst_txd", o_txd, 1'b1);
        chk_idle("midrst_st");
        i_reset = 1'b1;
        run_frame(8'hFF, -1, 8'h00, -1, "ff");

        sw = 8'h3C;
        run_frame(8'h3C, -1, 8'h00, 1, "p3c");
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pulse_hold", o_txd, 1'b1);
        end
        chk_idle("pulse_hold_st");

        sw      = 8'h07;
        i_start = 1'b1;
        run_frame(8'h07, -1, 8'h00, -1, "f07");
        i_start = 1'b0;
        step();
        chk("end_idle", o_txd, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_top.md
UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, i_clk cycles per serial bit period; legal range 2..65535.
REQ-002 i_clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 i_reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 i_start  input  1  level-sensitive transmit request; while 1, frames are sent repeatedly.
REQ-005 sw  input  8  data byte to transmit, sampled at frame start.
REQ-006 o_txd  output  1  serial line, idle high, registered output.

Function
REQ-007 The block SHALL be a UART transmitter with frame format: 1 start bit (0), 8 data bits LSB first, optional parity (REQ-020), 1 stop bit (1).
REQ-008 FSM states SHALL be IDLE, START, DATA, PARITY (only when configured), STOP.
REQ-009 IDLE: o_txd=1; on the edge where i_start=1, sw SHALL be latched into a shift register and the state SHALL become START.
REQ-010 o_txd SHALL change only on the edge that enters a new bit and SHALL be 0 one edge after the IDLE->START edge (latency 1 cycle from sampled i_start).
REQ-011 Each bit (start, each data, parity, stop) SHALL last exactly CLKS_PER_BIT cycles, counted by a baud counter that restarts at every bit boundary.
REQ-012 DATA SHALL output bit index 0..7 in order, with a 3-bit index wrapping 7->exit to PARITY/STOP.
REQ-013 After STOP completes, the state SHALL return to IDLE for exactly one cycle; if i_start is still 1 there, the next frame starts (10 or 11 bit periods + 1 cycle per frame).
REQ-014 Changes of sw during a frame SHALL NOT affect the frame in progress; the new value is used by the next frame.
REQ-015 i_start deasserting mid-frame SHALL NOT abort the frame; it completes, then IDLE holds.
REQ-016 i_start is ignored in every state except IDLE.

Reset
REQ-017 While i_reset=0 at a rising edge: state=IDLE, o_txd=1, baud counter=0, bit index=0, shift register=0.
REQ-018 Reset asserted mid-frame SHALL abort the frame; o_txd=1 after that edge; no partial frame resumes.
REQ-019 Before the first reset, outputs are undefined; i_start may be X until reset is released.

Configuration
REQ-020 Macro UART_PARITY_EN: when defined, an even-parity bit (XOR of the 8 latched data bits) SHALL be sent in state PARITY between DATA and STOP; when undefined, PARITY state and logic SHALL not exist and DATA goes directly to STOP.

Structure
REQ-021 Package uart_pkg SHALL hold the FSM state enum typedef and the default CLKS_PER_BIT constant.
REQ-022 A sub-module uart_baud_gen (counter generating a one-cycle bit_tick every CLKS_PER_BIT cycles, synchronous clear) is natural; FSM and shift register reside in uart_top.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-023 Reset: i_reset=0 for 2 edges with i_start=1 -> o_txd=1 throughout; state IDLE.
REQ-024 sw=8'hA5, i_start=1 then i_reset=1 -> o_txd sequence per 4 cycles: 0,1,0,1,0,0,1,0,1,1 (LSB first), then 1 idle cycle, next frame.
REQ-025 Continuous i_start=1, sw incremented 8'h00->8'h01 mid-frame -> current frame carries 8'h00, next frame carries 8'h01; frame period 41 cycles.
REQ-026 Reset asserted during data bit 3 of sw=8'hFF -> o_txd=1 one edge later; restart on release sends a full frame from the start bit.
REQ-027 i_start pulsed 1 cycle with sw=8'h3C, then 0 -> exactly one frame, then o_txd held 1.
REQ-028 UART_PARITY_EN defined, sw=8'h07 -> parity bit 1 before stop; frame period 45 cycles.
